i2s_rx_stereo: RTL and testbench



---
 rtl/i2s_pkg.sv | 28 ++
 rtl/i2s_rx_stereo_sync.sv | 48 ++++
 rtl/i2s_rx_stereo.sv | 166 ++++++++++++++++
 tb/tb_i2s_rx_stereo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared format codes, FSM encoding and sizing helper for the
//            stereo I2S receiver.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam logic FMT_I2S = 1'b0;
  localparam logic FMT_LJ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Never returns less than 1, so degenerate sizes still get a legal vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_rx_stereo_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2s_in_sync
// Brief    : Synchronises sck/ws/sd onto clk and issues a registered one-cycle
//            strobe on each rising edge of the synchronised bit clock.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic ws,
  input  logic sd,
  output logic bit_evt,
  output logic ws_s,
  output logic sd_s
);

  logic [SYNC_STAGES-1:0] r_sck_pipe;
  logic [SYNC_STAGES-1:0] r_ws_pipe;
  logic [SYNC_STAGES-1:0] r_sd_pipe;
  logic                   r_sck_prev;

  // ws/sd leave the same stage as sck so the strobe and its data stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_pipe <= '0;
      r_ws_pipe  <= '0;
      r_sd_pipe  <= '0;
      r_sck_prev <= 1'b0;
      bit_evt    <= 1'b0;
      ws_s       <= 1'b0;
      sd_s       <= 1'b0;
    end else begin
      r_sck_pipe <= {r_sck_pipe[SYNC_STAGES-2:0], sck};
      r_ws_pipe  <= {r_ws_pipe[SYNC_STAGES-2:0], ws};
      r_sd_pipe  <= {r_sd_pipe[SYNC_STAGES-2:0], sd};
      r_sck_prev <= r_sck_pipe[SYNC_STAGES-1];
      bit_evt    <= r_sck_pipe[SYNC_STAGES-1] & ~r_sck_prev;
      ws_s       <= r_ws_pipe[SYNC_STAGES-1];
      sd_s       <= r_sd_pipe[SYNC_STAGES-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_rx_stereo.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_stereo
// Brief    : Oversampling I2S / left-justified stereo receiver with frame lock
//            qualification and a valid/ready frame output with overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_stereo
  import i2s_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int SLOT_W      = 32,
  parameter int LOCK_FRAMES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fmt,
  input  logic              sck,
  input  logic              ws,
  input  logic              sd,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              overrun
);

  localparam int                   c_cnt_w     = clog2(SLOT_W);
  localparam int                   c_lock_w    = clog2(LOCK_FRAMES);
  localparam logic [c_cnt_w-1:0]   c_cnt_max   = c_cnt_w'(SLOT_W - 1);
  localparam logic [c_lock_w-1:0]  c_lock_last = c_lock_w'(LOCK_FRAMES - 1);
  localparam logic [DATA_W-1:0]    c_msb       = {1'b1, {(DATA_W-1){1'b0}}};

  logic w_bit_evt;
  logic w_ws_s;
  logic w_sd_s;

  i2s_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sck     (sck),
    .ws      (ws),
    .sd      (sd),
    .bit_evt (w_bit_evt),
    .ws_s    (w_ws_s),
    .sd_s    (w_sd_s)
  );

  state_t              r_state;
  logic                r_fmt;
  logic                r_ws_last;
  logic                r_ws_valid;
  logic [DATA_W-1:0]   r_slot;
  logic [DATA_W-1:0]   r_left_slot;
  logic [c_cnt_w-1:0]  r_bit_cnt;
  logic                r_cnt_full;
  logic [c_lock_w-1:0] r_lock_cnt;

  logic                w_left_lvl;
  logic                w_boundary;
  logic                w_into_left;
  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_slot_wr;
  logic [DATA_W-1:0]   w_ending;
  logic                w_frame_done;

  // The shifted mask falls off the end once the index reaches DATA_W,
  // which discards the surplus low-order bits of long slots for free.
  always_comb begin
    w_left_lvl   = (r_fmt == FMT_LJ);
    w_boundary   = w_bit_evt && r_ws_valid && (w_ws_s != r_ws_last);
    w_into_left  = w_boundary && (w_ws_s == w_left_lvl);
    w_mask       = r_cnt_full ? '0 : (c_msb >> r_bit_cnt);
    w_slot_wr    = r_slot | (w_sd_s ? w_mask : '0);
    w_ending     = (r_fmt == FMT_I2S) ? w_slot_wr : r_slot;
    w_frame_done = en && (r_state == ST_LOCKED) && w_into_left;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fmt       <= FMT_I2S;
      r_ws_last   <= 1'b0;
      r_ws_valid  <= 1'b0;
      r_slot      <= '0;
      r_left_slot <= '0;
      r_bit_cnt   <= '0;
      r_cnt_full  <= 1'b0;
      r_lock_cnt  <= '0;
      locked      <= 1'b0;
    end else if (!en) begin
      r_state     <= ST_IDLE;
      r_ws_valid  <= 1'b0;
      r_slot      <= '0;
      r_left_slot <= '0;
      r_bit_cnt   <= '0;
      r_cnt_full  <= 1'b0;
      r_lock_cnt  <= '0;
      locked      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_fmt   <= fmt;
          r_state <= ST_ACQUIRE;
        end
        default: begin
          if (w_bit_evt) begin
            r_ws_last  <= w_ws_s;
            r_ws_valid <= 1'b1;
            if (w_boundary) begin
              r_cnt_full <= 1'b0;
              // LJ: the boundary bit already belongs to the new slot.
              if (r_fmt == FMT_LJ) begin
                r_slot    <= w_sd_s ? c_msb : '0;
                r_bit_cnt <= c_cnt_w'(1);
              end else begin
                r_slot    <= '0;
                r_bit_cnt <= '0;
              end
              if (!w_into_left) r_left_slot <= w_ending;
              if (w_into_left && (r_state == ST_ACQUIRE)) begin
                if (r_lock_cnt == c_lock_last) begin
                  r_state <= ST_LOCKED;
                  locked  <= 1'b1;
                end else begin
                  r_lock_cnt <= r_lock_cnt + 1'b1;
                end
              end
            end else begin
              r_slot <= w_slot_wr;
              if (r_bit_cnt == c_cnt_max) r_cnt_full <= 1'b1;
              else                        r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // A pending frame survives en=0; only a new frame or a transfer changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_frame_done) begin
        out_left  <= r_left_slot;
        out_right <= w_ending;
        out_valid <= 1'b1;
        overrun   <= out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_stereo.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx_stereo
// Brief    : Scoreboard bench for i2s_rx_stereo driven by directed I2S/LJ frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_stereo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        fmt = 1'b0;
  logic        sck = 1'b0;
  logic        ws = 1'b0;
  logic        sd = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] out_left;
  logic [23:0] out_right;
  logic        out_valid;
  logic        locked;
  logic        overrun;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_e;
  int     checks = 0;
  int     errors = 0;
  int     ovr_cnt = 0;
  int     ovr_base = 0;

  localparam logic [31:0] c_l32 = 32'hABCDEF00;
  localparam logic [31:0] c_r32 = 32'h12345600;

  always #5 clk = ~clk;

  i2s_rx_stereo #(
    .DATA_W(24), .SLOT_W(32), .LOCK_FRAMES(2), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fmt(fmt),
    .sck(sck), .ws(ws), .sd(sd),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .locked(locked), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    exp_q.push_back({l, r});
  endtask

  // Called at a negedge; sck high phase ends 8 clk after it starts low.
  task automatic send_bit(input logic w, input logic d, input bit rdy_hook);
    sck = 1'b0; ws = w; sd = d;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(negedge clk);
    if (rdy_hook) out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_slot(input logic [31:0] data, input int n, input bit is_left,
                           input bit lj, input int first, input int last, input bit hook);
    logic lvl;
    logic w;
    lvl = is_left ? lj : !lj;
    for (int j = first; j <= last; j++) begin
      w = (!lj && j == n-1) ? !lvl : lvl;
      send_bit(w, data[n-1-j], hook && (j == last));
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                            input bit lj, input bit hook);
    send_slot(l, n, 1'b1, lj, 0, n-1, 1'b0);
    send_slot(r, n, 1'b0, lj, 0, n-1, hook);
  endtask

  // Monitor: every accepted frame is checked against the scoreboard head.
  initial forever begin
    @(negedge clk);
    #2;
    if (overrun) ovr_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got left=%h right=%h, required no frame", out_left, out_right);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_left", {8'h0, out_left}, {8'h0, mon_e.l});
        check("frame_right", {8'h0, out_right}, {8'h0, mon_e.r});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, out_valid}, 0);
    check("rst_left", {8'h0, out_left}, 0);
    check("rst_right", {8'h0, out_right}, 0);
    check("rst_locked", {31'h0, locked}, 0);
    check("rst_overrun", {31'h0, overrun}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // I2S, enable arrives in the middle of a right slot
    send_slot(c_l32, 32, 1'b1, 1'b0, 0, 31, 1'b0);
    send_slot(c_r32, 32, 1'b0, 1'b0, 0, 15, 1'b0);
    en = 1'b1;
    send_slot(c_r32, 32, 1'b0, 1'b0, 16, 31, 1'b0);
    check("i2s_lock_after_1", {31'h0, locked}, 0);
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b0);
    check("i2s_lock_after_2", {31'h0, locked}, 1);
    push(24'hABCDEF, 24'h123456);
    push(24'hABCDEF, 24'h123456);
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b0);
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("i2s_drain", exp_q.size(), 0);

    // Back-pressure: three frames unaccepted, then ready lands on a new frame
    ovr_base  = ovr_cnt;
    out_ready = 1'b0;
    send_frame(32'h11111100, 32'h22222200, 32, 1'b0, 1'b0);
    send_frame(32'h33333300, 32'h44444400, 32, 1'b0, 1'b0);
    send_frame(32'h55555500, 32'h66666600, 32, 1'b0, 1'b0);
    check("bp_valid_held", {31'h0, out_valid}, 1);
    push(24'h555555, 24'h666666);
    push(24'hABCDEF, 24'h123456);
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("bp_overrun_count", ovr_cnt - ovr_base, 2);
    check("bp_drain", exp_q.size(), 0);

    // Disable in the middle of a slot
    send_slot(c_l32, 32, 1'b1, 1'b0, 0, 15, 1'b0);
    en = 1'b0;
    @(negedge clk);
    check("unlock_on_disable", {31'h0, locked}, 0);
    send_slot(c_l32, 32, 1'b1, 1'b0, 16, 31, 1'b0);
    send_slot(c_r32, 32, 1'b0, 1'b0, 0, 31, 1'b0);
    repeat (4) @(negedge clk);
    check("disabled_no_valid", {31'h0, out_valid}, 0);

    // Left-justified; fmt toggled mid-run must be ignored
    fmt = 1'b1;
    en  = 1'b1;
    send_frame(c_l32, c_r32, 32, 1'b1, 1'b0);
    send_frame(c_l32, c_r32, 32, 1'b1, 1'b0);
    check("lj_lock_after_2", {31'h0, locked}, 0);
    send_frame(c_l32, c_r32, 32, 1'b1, 1'b0);
    check("lj_lock_after_3", {31'h0, locked}, 1);
    push(24'hABCDEF, 24'h123456);
    push(24'hABCDEF, 24'h123456);
    fmt = 1'b0;
    send_frame(c_l32, c_r32, 32, 1'b1, 1'b0);
    send_frame(c_l32, c_r32, 32, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("lj_drain", exp_q.size(), 0);
    en = 1'b0;
    repeat (2) @(negedge clk);

    // 16-bit slots: short samples are MSB-aligned with zero LSBs
    en = 1'b1;
    send_frame(32'h00008001, 32'h00007FFF, 16, 1'b0, 1'b0);
    send_frame(32'h00008001, 32'h00007FFF, 16, 1'b0, 1'b0);
    check("s16_lock", {31'h0, locked}, 1);
    push(24'h800100, 24'h7FFF00);
    push(24'h800100, 24'h7FFF00);
    send_frame(32'h00008001, 32'h00007FFF, 16, 1'b0, 1'b0);
    send_frame(32'h00008001, 32'h00007FFF, 16, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("s16_drain", exp_q.size(), 0);
    en = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-slot with a frame pending
    out_ready = 1'b0;
    en = 1'b1;
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b0);
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b0);
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b0);
    check("pend_valid", {31'h0, out_valid}, 1);
    check("pend_left", {8'h0, out_left}, 32'hABCDEF);
    send_slot(c_l32, 32, 1'b1, 1'b0, 0, 15, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, out_valid}, 0);
    check("arst_left", {8'h0, out_left}, 0);
    check("arst_right", {8'h0, out_right}, 0);
    check("arst_locked", {31'h0, locked}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b0);
    check("relock_after_1", {31'h0, locked}, 0);
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b0);
    check("relock_after_2", {31'h0, locked}, 1);
    push(24'hABCDEF, 24'h123456);
    send_frame(c_l32, c_r32, 32, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
